bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_id_fifo.sv | 79 +++++++
 rtl/bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the bus arbiter and its ID FIFO:
//   - legal parameter ranges for host count and outstanding depth
//   - idx_width(): bit width needed to hold an index in 0..n-1 (minimum 1)
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam int MinHosts       = 2;
  localparam int MaxHosts       = 8;
  localparam int MinOutstanding = 1;
  localparam int MaxOutstanding = 4;

  // Width of an index into n entries; never narrower than one bit so that
  // single-entry structures still get a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// bus_arbiter_id_fifo
// Small FIFO holding the host index of every accepted downstream transfer so
// that responses can be routed back in acceptance order.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset (clears pointers/occupancy)
//   push_i     in   write push_id_i at the tail (ignored when full)
//   push_id_i  in   host index to store
//   pop_i      in   drop the head entry (ignored when empty)
//   full_o     out  Depth entries stored
//   empty_o    out  no entries stored
//   head_o     out  oldest stored host index (meaningful only when !empty_o)
// -----------------------------------------------------------------------------
module bus_arbiter_id_fifo
  import bus_arbiter_pkg::*;
#(
  parameter int Depth   = 2,
  parameter int IdWidth = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [IdWidth-1:0] push_id_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [IdWidth-1:0] head_o
);

  localparam int CntWidth = $clog2(Depth + 1);
  localparam int PtrWidth = idx_width(Depth);

  logic [IdWidth-1:0]  r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) return '0;
    return p + PtrWidth'(1);
  endfunction

  assign full_o  = (r_count == CntWidth'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rd_ptr];

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides whether
  // an entry is live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_id_i;
  end

endmodule : bus_arbiter_id_fifo

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter multiplexing NrHosts request/grant hosts onto a single
// downstream device port, with up to MaxOutstanding accepted transfers
// awaiting in-order responses.
//
// Ports (per-host buses are packed, host h occupies slice h):
//   clk_i, rst_i                      clock / synchronous active-high reset
//   host_req_i      [NrHosts]         request
//   host_gnt_o      [NrHosts]         grant (same cycle as downstream accept)
//   host_addr_i     [NrHosts*AW]      address
//   host_we_i       [NrHosts]         write enable
//   host_be_i       [NrHosts*DW/8]    byte enables
//   host_wdata_i    [NrHosts*DW]      write data
//   host_rvalid_o   [NrHosts]         response valid
//   host_rdata_o    [NrHosts*DW]      read data (zero unless selected)
//   host_err_o      [NrHosts]         response error
//   dev_req_o/addr/we/be/wdata        arbitrated downstream request
//   dev_gnt_i/rvalid/rdata/err        downstream grant and response
//   unexp_rsp_o                       sticky: response with nothing pending
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0]  host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic                              dev_req_o,
  output logic [AddressWidth-1:0]           dev_addr_o,
  output logic                              dev_we_o,
  output logic [DataWidth/8-1:0]            dev_be_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_gnt_i,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              unexp_rsp_o
);

  localparam int IdWidth = idx_width(NrHosts);
  localparam int BeWidth = DataWidth / 8;

  // Reject illegal configurations at elaboration time.
  if (NrHosts < MinHosts || NrHosts > MaxHosts) begin : g_bad_hosts
    $error("bus_arbiter: NrHosts must be in 2..8");
  end
  if (MaxOutstanding < MinOutstanding ||
      MaxOutstanding > bus_arbiter_pkg::MaxOutstanding) begin : g_bad_outstanding
    $error("bus_arbiter: MaxOutstanding must be in 1..4");
  end
  if (DataWidth < 8 || (DataWidth % 8) != 0) begin : g_bad_data_width
    $error("bus_arbiter: DataWidth must be a non-zero multiple of 8");
  end
  if (AddressWidth < 1) begin : g_bad_addr_width
    $error("bus_arbiter: AddressWidth must be at least 1");
  end

  logic [IdWidth-1:0] r_last_grant;
  logic               r_lock_valid;
  logic [IdWidth-1:0] r_lock_idx;
  logic               r_unexp;

  logic [IdWidth-1:0] w_rr_idx;
  logic               w_rr_found;
  logic               w_lock_req;
  logic               w_lock_hold;
  logic [IdWidth-1:0] w_winner;
  logic               w_any_req;
  logic               w_accept;
  logic               w_rsp;
  logic               w_full;
  logic               w_empty;
  logic [IdWidth-1:0] w_head;

  // Round-robin search: first requester at or after last_grant+1.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    for (int k = 1; k <= NrHosts; k++) begin
      v_idx = (int'(r_last_grant) + k) % NrHosts;
      for (int h = 0; h < NrHosts; h++) begin
        if (!w_rr_found && h == v_idx && host_req_i[h]) begin
          w_rr_found = 1'b1;
          w_rr_idx   = IdWidth'(h);
        end
      end
    end
  end

  // A request presented but not granted last cycle stays the winner while
  // its host keeps requesting, so a host holding its fields is never
  // overtaken by a newcomer with better round-robin position.
  always_comb begin
    w_lock_req = 1'b0;
    for (int h = 0; h < NrHosts; h++) begin
      if (int'(r_lock_idx) == h) w_lock_req = host_req_i[h];
    end
  end

  assign w_lock_hold = r_lock_valid & w_lock_req;
  assign w_winner    = w_lock_hold ? r_lock_idx : w_rr_idx;
  assign w_any_req   = |host_req_i;
  // A full ID FIFO blocks acceptance even if a response pops this cycle.
  assign dev_req_o   = w_any_req & ~w_full;
  assign w_accept    = dev_req_o & dev_gnt_i;
  assign w_rsp       = dev_rvalid_i & ~w_empty;
  assign unexp_rsp_o = r_unexp;

  // Downstream request mux and grant decode.
  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    host_gnt_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (dev_req_o && int'(w_winner) == h) begin
        dev_addr_o    = host_addr_i[h*AddressWidth +: AddressWidth];
        dev_we_o      = host_we_i[h];
        dev_be_o      = host_be_i[h*BeWidth +: BeWidth];
        dev_wdata_o   = host_wdata_i[h*DataWidth +: DataWidth];
        host_gnt_o[h] = dev_gnt_i;
      end
    end
  end

  // Response routing to the host at the FIFO head.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_rsp && int'(w_head) == h) begin
        host_rvalid_o[h]                       = 1'b1;
        host_err_o[h]                          = dev_err_i;
        host_rdata_o[h*DataWidth +: DataWidth] = dev_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= IdWidth'(NrHosts - 1);
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      r_unexp      <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_winner;
      r_lock_valid <= dev_req_o & ~dev_gnt_i;
      r_lock_idx   <= w_winner;
      if (dev_rvalid_i && w_empty) r_unexp <= 1'b1;
    end
  end

  bus_arbiter_id_fifo #(
    .Depth   (MaxOutstanding),
    .IdWidth (IdWidth)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_accept),
    .push_id_i (w_winner),
    .pop_i     (w_rsp),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .head_o    (w_head)
  );

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed vectors for the default configuration (2 hosts, 32-bit, depth 2).
// Each vector drives one clock cycle and carries hand-computed expectations:
// the grant and response it should produce go into scoreboard queues, and a
// negedge monitor compares them whenever the DUT presents a grant or rvalid.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NH-1:0]     host_req_i;
  logic [NH-1:0]     host_gnt_o;
  logic [NH*AW-1:0]  host_addr_i;
  logic [NH-1:0]     host_we_i;
  logic [NH*DW/8-1:0] host_be_i;
  logic [NH*DW-1:0]  host_wdata_i;
  logic [NH-1:0]     host_rvalid_o;
  logic [NH*DW-1:0]  host_rdata_o;
  logic [NH-1:0]     host_err_o;
  logic              dev_req_o;
  logic [AW-1:0]     dev_addr_o;
  logic              dev_we_o;
  logic [DW/8-1:0]   dev_be_o;
  logic [DW-1:0]     dev_wdata_o;
  logic              dev_gnt_i;
  logic              dev_rvalid_i;
  logic [DW-1:0]     dev_rdata_i;
  logic              dev_err_i;
  logic              unexp_rsp_o;

  bus_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .dev_req_o     (dev_req_o),
    .dev_addr_o    (dev_addr_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_wdata_o   (dev_wdata_o),
    .dev_gnt_i     (dev_gnt_i),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rdata_i   (dev_rdata_i),
    .dev_err_i     (dev_err_i),
    .unexp_rsp_o   (unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          rst;
    logic [NH-1:0] req;
    logic          gnt;
    logic          rv;
    logic [DW-1:0] rdata;
    logic          err;
    int            eg;      // expected granted host, -1 none
    int            er;      // expected responding host, -1 none
    int            edreq;   // expected dev_req_o, -1 don't care
    int            eunexp;  // expected unexp_rsp_o, -1 don't care
  } vec_t;

  typedef struct { int host; int cyc; } gnt_exp_t;
  typedef struct { int host; int cyc; logic [DW-1:0] data; logic err; } rsp_exp_t;

  vec_t     vq[$];
  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = -1;

  // Fixed per-host request fields: host h uses address A000_0000 + 16*h.
  localparam logic [AW-1:0]   Addr0  = 32'hA000_0000;
  localparam logic [AW-1:0]   Addr1  = 32'hA000_0010;
  localparam logic [DW-1:0]   Wdata0 = 32'h5500_0000;
  localparam logic [DW-1:0]   Wdata1 = 32'h5500_0001;
  localparam logic [DW/8-1:0] Be0    = 4'h3;
  localparam logic [DW/8-1:0] Be1    = 4'hC;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic rst, input logic [NH-1:0] req, input logic gnt,
                     input logic rv, input logic [DW-1:0] rdata, input logic err,
                     input int eg, input int er, input int edreq, input int eunexp);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
    v.eg = eg; v.er = er; v.edreq = edreq; v.eunexp = eunexp;
    vq.push_back(v);
  endtask

  // Scoreboard monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk_i) begin
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      check("gnt_missing", 64'(host_gnt_o), 64'(1) << gq[0].host);
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      check("rsp_missing", 64'(host_rvalid_o), 64'(1) << rq[0].host);
      void'(rq.pop_front());
    end
    if (host_gnt_o != '0) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", 64'(host_gnt_o), 64'(0));
      end else begin
        gnt_exp_t g;
        g = gq.pop_front();
        check("gnt_host",  64'(host_gnt_o), 64'(1) << g.host);
        check("gnt_cycle", 64'(cyc), 64'(g.cyc));
        check("gnt_addr",  64'(dev_addr_o),  64'(g.host == 1 ? Addr1 : Addr0));
        check("gnt_wdata", 64'(dev_wdata_o), 64'(g.host == 1 ? Wdata1 : Wdata0));
        check("gnt_be",    64'(dev_be_o),    64'(g.host == 1 ? Be1 : Be0));
        check("gnt_we",    64'(dev_we_o),    64'(g.host == 1 ? 1 : 0));
      end
    end
    if (host_rvalid_o != '0) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", 64'(host_rvalid_o), 64'(0));
      end else begin
        rsp_exp_t r;
        logic [NH*DW-1:0] exp_rdata;
        r = rq.pop_front();
        exp_rdata = '0;
        exp_rdata[r.host*DW +: DW] = r.data;
        check("rsp_host",  64'(host_rvalid_o), 64'(1) << r.host);
        check("rsp_cycle", 64'(cyc), 64'(r.cyc));
        check("rsp_rdata", 64'(host_rdata_o), 64'(exp_rdata));
        check("rsp_err",   64'(host_err_o), 64'(r.err) << r.host);
      end
    end else begin
      check("idle_rdata_zero", 64'(host_rdata_o), 64'(0));
    end
  end

  initial begin
    host_addr_i  = {Addr1, Addr0};
    host_wdata_i = {Wdata1, Wdata0};
    host_be_i    = {Be1, Be0};
    host_we_i    = 2'b10;
    rst_i        = 1'b1;
    host_req_i   = '0;
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;

    //   rst req   gnt rv rdata          err eg  er  dreq unexp
    // Reset, then idle reset state.
    add(1, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0, -1);
    add(1, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  0);
    add(0, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  0);
    // Both hosts request continuously, response one cycle after grant.
    add(0, 2'b11, 1, 0, 32'h0,          0,  0, -1, 1,  0);
    add(0, 2'b11, 1, 1, 32'h1111_1111,  0,  1,  0, 1,  0);
    add(0, 2'b11, 1, 1, 32'h2222_2222,  0,  0,  1, 1,  0);
    add(0, 2'b11, 1, 1, 32'h3333_3333,  0,  1,  0, 1,  0);
    add(0, 2'b00, 0, 1, 32'h4444_4444,  0, -1,  1, 0,  0);
    // Host 0 issues three requests with responses withheld: FIFO fills.
    add(0, 2'b01, 1, 0, 32'h0,          0,  0, -1, 1,  0);
    add(0, 2'b01, 1, 0, 32'h0,          0,  0, -1, 1,  0);
    add(0, 2'b01, 1, 0, 32'h0,          0, -1, -1, 0,  0);
    add(0, 2'b01, 1, 1, 32'h5555_5555,  0, -1,  0, 0,  0);
    add(0, 2'b01, 1, 0, 32'h0,          0,  0, -1, 1,  0);
    add(0, 2'b00, 0, 1, 32'h6666_6666,  0, -1,  0, 0,  0);
    add(0, 2'b00, 0, 1, 32'h7777_7777,  0, -1,  0, 0,  0);
    // Host 1 transfer so that host 0 holds round-robin priority next.
    add(0, 2'b10, 1, 0, 32'h0,          0,  1, -1, 1,  0);
    add(0, 2'b00, 0, 1, 32'h8888_8888,  0, -1,  1, 0,  0);
    // Host 1 stalled by dev_gnt_i low; host 0 joins but must wait its turn.
    add(0, 2'b10, 0, 0, 32'h0,          0, -1, -1, 1,  0);
    add(0, 2'b10, 0, 0, 32'h0,          0, -1, -1, 1,  0);
    add(0, 2'b11, 0, 0, 32'h0,          0, -1, -1, 1,  0);
    add(0, 2'b11, 0, 0, 32'h0,          0, -1, -1, 1,  0);
    add(0, 2'b11, 1, 0, 32'h0,          0,  1, -1, 1,  0);
    add(0, 2'b01, 1, 0, 32'h0,          0,  0, -1, 1,  0);
    add(0, 2'b00, 0, 1, 32'h9999_9999,  0, -1,  1, 0,  0);
    add(0, 2'b00, 0, 1, 32'hAAAA_AAAA,  0, -1,  0, 0,  0);
    // Error response to host 1.
    add(0, 2'b10, 1, 0, 32'h0,          0,  1, -1, 1,  0);
    add(0, 2'b00, 0, 1, 32'hBBBB_BBBB,  1, -1,  1, 0,  0);
    // Response with nothing outstanding: dropped, sticky flag.
    add(0, 2'b00, 0, 1, 32'hDEAD_BEEF,  0, -1, -1, 0,  0);
    add(0, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  1);
    add(0, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  1);
    // Two accepted, reset, then two orphan responses, then host 0 first.
    add(0, 2'b01, 1, 0, 32'h0,          0,  0, -1, 1,  1);
    add(0, 2'b10, 1, 0, 32'h0,          0,  1, -1, 1,  1);
    add(1, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  1);
    add(0, 2'b00, 0, 1, 32'hCCCC_CCCC,  0, -1, -1, 0,  0);
    add(0, 2'b00, 0, 1, 32'hDDDD_DDDD,  0, -1, -1, 0,  1);
    add(0, 2'b11, 1, 0, 32'h0,          0,  0, -1, 1,  1);
    add(0, 2'b00, 0, 1, 32'hEEEE_EEEE,  0, -1,  0, 0,  1);
    add(0, 2'b00, 0, 0, 32'h0,          0, -1, -1, 0,  1);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk_i);
      #1;
      cyc          = i;
      rst_i        = vq[i].rst;
      host_req_i   = vq[i].req;
      dev_gnt_i    = vq[i].gnt;
      dev_rvalid_i = vq[i].rv;
      dev_rdata_i  = vq[i].rdata;
      dev_err_i    = vq[i].err;
      if (vq[i].eg >= 0) gq.push_back('{host: vq[i].eg, cyc: i});
      if (vq[i].er >= 0) rq.push_back('{host: vq[i].er, cyc: i, data: vq[i].rdata, err: vq[i].err});
      #1;
      if (vq[i].edreq >= 0)  check("dev_req", 64'(dev_req_o), 64'(vq[i].edreq));
      if (vq[i].eunexp >= 0) check("unexp_rsp", 64'(unexp_rsp_o), 64'(vq[i].eunexp));
    end

    @(posedge clk_i);
    #1;
    cyc          = vq.size();
    host_req_i   = '0;
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("gnt_queue_drained", 64'(gq.size()), 64'(0));
    check("rsp_queue_drained", 64'(rq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_arbiter
